alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Sequential initiator for the 32-bit ALU. It accepts one operation request over a valid/ready handshake and decodes MIPS ALUOp/funct into the 4-bit ALU control code. It drives the ALU operand and control ports, waits a fixed settle interval, then captures BusW/Zero and returns them over a valid/ready response handshake. It sits between the decode stage of the multicycle datapath and the ALU.

## Interface
- N, 32, datapath width
- SETTLE, 2, cycles the ALU inputs are held before capture; legal range 1..15

- CLK  in  1  clock, rising edge
- Reset_L  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 lui
- req_funct  in  6  R-type funct field (used when req_aluop=10)
- req_shamt  in  5  shift amount
- req_a  in  N  rs operand
- req_b  in  N  rt/immediate operand
- alu_a  out  N  to ALU BusA
- alu_b  out  N  to ALU BusB
- alu_ctrl  out  4  to ALU ALUCtrl
- alu_w  in  N  from ALU BusW
- alu_zero  in  1  from ALU Zero
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result
- rsp_data  out  N  captured BusW
- rsp_zero  out  1  captured Zero
- rsp_err  out  1  illegal funct; no ALU op issued

## Operation
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE. rsp_valid=1 only in RESP.
- Accept = req_valid & req_ready at a rising edge (edge E0).
- Decode at accept:
  - aluop 00 → 0010 (ADD)
  - aluop 01 → 0110 (SUB)
  - aluop 11 → 1110 (LUI)
  - aluop 10, by funct: 0x20→0010, 0x21→1000, 0x22→0110, 0x23→1001, 0x24→0000, 0x25→0001, 0x26→1010, 0x27→1100, 0x2A→0111, 0x2B→1011, 0x00→0011, 0x02→0100, 0x03→1101.
- Operand mapping at accept:
  - Shifts (funct 0x00/0x02/0x03): alu_a←req_b, alu_b←{27'b0, req_shamt}.
  - All other ops: alu_a←req_a, alu_b←req_b.
- Legal op: alu_a/alu_b/alu_ctrl registered at E0 → WAIT, settle counter←SETTLE-1.
- Illegal funct (aluop 10, any funct not listed): alu_* unchanged → RESP with rsp_err=1, rsp_data=0, rsp_zero=0.
- WAIT:
  - Each edge with counter≠0 decrements it.
  - At the edge with counter=0: rsp_data←alu_w, rsp_zero←alu_zero, rsp_err←0 → RESP.
- RESP: hold all rsp_* stable until rsp_valid & rsp_ready at an edge → IDLE.
- alu_a/alu_b/alu_ctrl change only at accept of a legal op; they persist after the response.

## Timing
- Reset (Reset_L=0 at an edge), regardless of state: state=IDLE, counter=0, alu_a=0, alu_b=0, alu_ctrl=0000, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0. req_ready=1 from the first cycle after reset.
- Reset mid-WAIT or mid-RESP aborts the operation; no response is ever produced for it.
- Legal latency: rsp_valid rises at edge E0+SETTLE (SETTLE=2 → two edges after accept).
- Illegal latency: rsp_valid rises at edge E0 (visible the cycle after accept).
- Throughput: at most one op per SETTLE+2 cycles with rsp_ready held high; a new request is not accepted in the cycle the response completes (IDLE is entered at that edge).
- req_* are sampled only at accept; changes at other times are ignored.
- alu_w/alu_zero are sampled only at the capture edge.
- rsp_ready outside RESP has no effect.

## Test plan
- Reset, then aluop=10 funct=0x20 a=5 b=7, alu_w=12 returned, rsp_ready=1 → alu_ctrl=0010, alu_a=5, alu_b=7; rsp_valid at E0+2 with rsp_data=12, rsp_zero=0, rsp_err=0; req_ready=1 one cycle later.
- aluop=10 funct=0x00 shamt=4 b=0x1 → alu_a=0x1, alu_b=4, alu_ctrl=0011; captured rsp_data=0x10.
- aluop=01 a=9 b=9, ALU returns alu_w=0 and alu_zero=1 → alu_ctrl=0110; rsp_zero=1, rsp_data=0.
- aluop=10 funct=0x3F → rsp_valid at E0 with rsp_err=1 and rsp_data=0; alu_ctrl keeps its previous value.
- Legal op with rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable throughout and req_ready=0; single completion when rsp_ready=1.
- Reset_L=0 one cycle after accept (WAIT) → all outputs at reset values, no rsp_valid pulse; the next request completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Sequential ALU initiator: accepts one decoded MIPS op, holds ALU inputs for a
// settle interval, then returns the captured BusW/Zero over a response handshake.
module alu_issue_ctrl #(
  parameter int unsigned N      = 32,
  parameter int unsigned SETTLE = 2
) (
  input  logic         CLK,
  input  logic         Reset_L,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_aluop,
  input  logic [5:0]   req_funct,
  input  logic [4:0]   req_shamt,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_w,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_err
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic [N-1:0]   aluANext, aluBNext, rspDataNext;
  logic [3:0]     aluCtrlNext;
  logic           rspZeroNext, rspErrNext, reqReadyNext, rspValidNext;

  logic [3:0]     decCtrl;
  logic           decLegal, decShift;

  // ALUOp/funct decode into the ALU control code
  always_comb begin
    decCtrl  = 4'b0000;
    decLegal = 1'b1;
    decShift = 1'b0;
    case (req_aluop)
      2'b00: decCtrl = 4'b0010;
      2'b01: decCtrl = 4'b0110;
      2'b11: decCtrl = 4'b1110;
      default: begin
        case (req_funct)
          6'h20: decCtrl = 4'b0010;
          6'h21: decCtrl = 4'b1000;
          6'h22: decCtrl = 4'b0110;
          6'h23: decCtrl = 4'b1001;
          6'h24: decCtrl = 4'b0000;
          6'h25: decCtrl = 4'b0001;
          6'h26: decCtrl = 4'b1010;
          6'h27: decCtrl = 4'b1100;
          6'h2A: decCtrl = 4'b0111;
          6'h2B: decCtrl = 4'b1011;
          6'h00: begin decCtrl = 4'b0011; decShift = 1'b1; end
          6'h02: begin decCtrl = 4'b0100; decShift = 1'b1; end
          6'h03: begin decCtrl = 4'b1101; decShift = 1'b1; end
          default: decLegal = 1'b0;
        endcase
      end
    endcase
  end

  // Next-state and next-register values
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    aluANext    = alu_a;
    aluBNext    = alu_b;
    aluCtrlNext = alu_ctrl;
    rspDataNext = rsp_data;
    rspZeroNext = rsp_zero;
    rspErrNext  = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (decLegal) begin
            // Shifts take the shifted value from rt and the amount from shamt
            aluANext    = decShift ? req_b : req_a;
            aluBNext    = decShift ? N'(req_shamt) : req_b;
            aluCtrlNext = decCtrl;
            cntNext     = CntInit;
            stateNext   = WAIT;
          end else begin
            rspDataNext = '0;
            rspZeroNext = 1'b0;
            rspErrNext  = 1'b1;
            stateNext   = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cntNext = cnt - CntW'(1);
        end else begin
          rspDataNext = alu_w;
          rspZeroNext = alu_zero;
          rspErrNext  = 1'b0;
          stateNext   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    reqReadyNext = (stateNext == IDLE);
    rspValidNext = (stateNext == RESP);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= 4'b0000;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      alu_a     <= aluANext;
      alu_b     <= aluBNext;
      alu_ctrl  <= aluCtrlNext;
      rsp_data  <= rspDataNext;
      rsp_zero  <= rspZeroNext;
      rsp_err   <= rspErrNext;
      req_ready <= reqReadyNext;
      rsp_valid <= rspValidNext;
    end
  end

endmodule
